rst_sequencer: RTL and testbench

//  Consumer end of the PLL clock tree: turns the raw PLL lock flag into ordered, glitch-free domain resets.

---
 rtl/rst_sequencer_pkg.sv | 22 ++
 rtl/rst_sequencer_cdc_bit_sync.sv | 24 ++
 rtl/rst_sequencer.sv | 137 +++++++++++++
 tb/tb_rst_sequencer.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/rst_sequencer_pkg.sv
// Shared types and constants for the reset sequencer: FSM states, stage
// indices and the saturating increment used by the lock-loss counter.
package rst_sequencer_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STABLE    = 2'd1,
        RELEASE   = 2'd2,
        RUN       = 2'd3
    } state_t;

    localparam int STG_MEM    = 0;
    localparam int STG_CORE   = 1;
    localparam int STG_LOADER = 2;
    localparam int STG_CPU    = 3;
    localparam int NUM_STG    = 4;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/rst_sequencer_cdc_bit_sync.sv
// Multi-flop synchroniser for one asynchronous level signal, cleared by the
// asynchronous reset.
module cdc_bit_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/rst_sequencer.sv
// Turns the raw PLL lock flag into ordered domain resets:
// mem -> core -> loader -> cpu, once lock has been stable long enough.
//
// state     | meaning
// WAIT_LOCK | all resets asserted, waiting for synchronised lock
// STABLE    | counting consecutive lock cycles
// RELEASE   | releasing one reset every STAGE_GAP cycles
// RUN       | all resets released, sys_ready high
module rst_sequencer
    import rst_sequencer_pkg::*;
#(
    parameter int SYNC_STAGES        = 2,
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int STAGE_GAP          = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       locked,
    input  logic       soft_rst_req,
    output logic       rst_mem,
    output logic       rst_core,
    output logic       rst_loader,
    output logic       rst_cpu,
    output logic       sys_ready,
    output logic [7:0] lock_loss_cnt
);

    localparam int CNT_MAX = (LOCK_STABLE_CYCLES > STAGE_GAP) ? LOCK_STABLE_CYCLES : STAGE_GAP;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;
    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(STAGE_GAP - 1);

    logic               lock_s;
    state_t             state, state_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [1:0]         stage, stage_n, next_stg;
    logic [NUM_STG-1:0] rst_vec, rst_vec_n;
    logic               ready, ready_n;
    logic [7:0]         loss, loss_n;

    cdc_bit_sync #(.STAGES(SYNC_STAGES)) u_lock_sync (
        .clk (clk),
        .rst (rst),
        .d   (locked),
        .q   (lock_s)
    );

    assign next_stg = stage + 2'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= WAIT_LOCK;
            cnt     <= '0;
            stage   <= '0;
            rst_vec <= '1;
            ready   <= 1'b0;
            loss    <= '0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            stage   <= stage_n;
            rst_vec <= rst_vec_n;
            ready   <= ready_n;
            loss    <= loss_n;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        stage_n   = stage;
        rst_vec_n = rst_vec;
        ready_n   = ready;
        loss_n    = loss;
        case (state)
            WAIT_LOCK: begin
                rst_vec_n = '1;
                ready_n   = 1'b0;
                if (lock_s) begin
                    state_n = STABLE;
                    cnt_n   = '0;
                end
            end
            STABLE: begin
                if (!lock_s || soft_rst_req) begin
                    state_n = WAIT_LOCK;
                    cnt_n   = '0;
                end else if (cnt == LOCK_LAST) begin
                    state_n            = RELEASE;
                    cnt_n              = '0;
                    stage_n            = 2'(STG_MEM);
                    rst_vec_n[STG_MEM] = 1'b0;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            RELEASE, RUN: begin
                // Lock loss takes priority over a coincident soft request so it is always counted.
                if (!lock_s || soft_rst_req) begin
                    state_n   = WAIT_LOCK;
                    cnt_n     = '0;
                    stage_n   = '0;
                    rst_vec_n = '1;
                    ready_n   = 1'b0;
                    if (!lock_s) begin
                        loss_n = sat_inc(loss);
                    end
                end else if (state == RELEASE) begin
                    if (cnt == GAP_LAST) begin
                        cnt_n               = '0;
                        stage_n             = next_stg;
                        rst_vec_n[next_stg] = 1'b0;
                        if (next_stg == 2'(STG_CPU)) begin
                            ready_n = 1'b1;
                            state_n = RUN;
                        end
                    end else begin
                        cnt_n = cnt + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_n   = WAIT_LOCK;
                rst_vec_n = '1;
                ready_n   = 1'b0;
            end
        endcase
    end

    assign rst_mem       = rst_vec[STG_MEM];
    assign rst_core      = rst_vec[STG_CORE];
    assign rst_loader    = rst_vec[STG_LOADER];
    assign rst_cpu       = rst_vec[STG_CPU];
    assign sys_ready     = ready;
    assign lock_loss_cnt = loss;

endmodule

// File: tb/tb_rst_sequencer.sv
// Bench for rst_sequencer: directed lock/soft-reset scenarios, a per-cycle
// check against an elapsed-time model, and literal checks at key edges.
module tb_rst_sequencer;

    localparam int L = 8;
    localparam int G = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       locked = 1'b0;
    logic       soft_rst_req = 1'b0;
    logic       rst_mem, rst_core, rst_loader, rst_cpu, sys_ready;
    logic [7:0] lock_loss_cnt;

    int checks = 0;
    int failures = 0;

    rst_sequencer #(
        .SYNC_STAGES        (2),
        .LOCK_STABLE_CYCLES (L),
        .STAGE_GAP          (G)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .locked        (locked),
        .soft_rst_req  (soft_rst_req),
        .rst_mem       (rst_mem),
        .rst_core      (rst_core),
        .rst_loader    (rst_loader),
        .rst_cpu       (rst_cpu),
        .sys_ready     (sys_ready),
        .lock_loss_cnt (lock_loss_cnt)
    );

    always #5 clk = ~clk;

    // Model: elapsed = edges since the synchronised lock started the sequence, -1 when waiting.
    // Released stage count follows from elapsed arithmetically.
    int         elapsed = -1;
    logic [7:0] m_cnt = '0;
    logic       p0 = 1'b0;
    logic       p1 = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            elapsed <= -1;
            m_cnt   <= '0;
            p0      <= 1'b0;
            p1      <= 1'b0;
        end else begin
            p0 <= locked;
            p1 <= p0;
            if (elapsed < 0) begin
                if (p1) elapsed <= 0;
            end else if (!p1) begin
                if (elapsed >= L) m_cnt <= (m_cnt == 8'd255) ? m_cnt : m_cnt + 8'd1;
                elapsed <= -1;
            end else if (soft_rst_req) begin
                elapsed <= -1;
            end else if (elapsed < L + 3*G) begin
                elapsed <= elapsed + 1;
            end
        end
    end

    function automatic logic [12:0] expv(input int e, input logic [7:0] c);
        return {e < L, e < L + G, e < L + 2*G, e < L + 3*G, e >= L + 3*G, c};
    endfunction

    function automatic logic [12:0] dutv();
        return {rst_mem, rst_core, rst_loader, rst_cpu, sys_ready, lock_loss_cnt};
    endfunction

    task automatic chk(input string name, input logic [12:0] act, input logic [12:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        bit run_cmp;
        run_cmp = 1'b1;
        #1 rst = 1'b1;

        fork
            begin
                while (run_cmp) begin
                    @(negedge clk);
                    if (run_cmp) chk("model_cycle", dutv(), expv(elapsed, m_cnt));
                end
            end
        join_none

        ticks(3);
        chk("reset_values", dutv(), 13'b1111_0_00000000);
        rst = 1'b0;
        ticks(3);

        // 1. Power-up: next edge is edge 0.
        locked = 1'b1;
        ticks(10);
        chk("pu_mem_e9", {12'd0, rst_mem}, 13'd1);
        ticks(1);
        chk("pu_e10", {11'd0, rst_mem, rst_core}, 13'b01);
        ticks(4);
        chk("pu_e14", {11'd0, rst_core, rst_loader}, 13'b01);
        ticks(4);
        chk("pu_e18", {10'd0, rst_loader, rst_cpu, sys_ready}, 13'b010);
        ticks(3);
        chk("pu_e21", {11'd0, rst_cpu, sys_ready}, 13'b10);
        ticks(1);
        chk("pu_e22", dutv(), 13'b0000_1_00000000);

        // 3. Lock loss in RUN; locked falls at edge E (now).
        locked = 1'b0;
        ticks(2);
        chk("loss_e2_still_run", dutv(), 13'b0000_1_00000000);
        ticks(1);
        chk("loss_e3", dutv(), 13'b1111_0_00000001);
        locked = 1'b1;
        ticks(10);
        chk("relock_mem_e9", {12'd0, rst_mem}, 13'd1);
        ticks(1);
        chk("relock_mem_e10", {12'd0, rst_mem}, 13'd0);
        ticks(12);
        chk("relock_run", dutv(), 13'b0000_1_00000001);

        // 4. Soft request in RUN.
        soft_rst_req = 1'b1;
        ticks(1);
        soft_rst_req = 1'b0;
        chk("soft_assert", dutv(), 13'b1111_0_00000001);
        ticks(8);
        chk("soft_mem_s8", {12'd0, rst_mem}, 13'd1);
        ticks(1);
        chk("soft_mem_s9", {12'd0, rst_mem}, 13'd0);

        // Lock loss during RELEASE, then 2. lock glitch.
        locked = 1'b0;
        ticks(5);
        chk("release_loss", dutv(), 13'b1111_0_00000010);
        locked = 1'b1;
        ticks(5);
        locked = 1'b0;
        ticks(1);
        locked = 1'b1;
        ticks(10);
        chk("glitch_mem_e15", {12'd0, rst_mem}, 13'd1);
        ticks(1);
        chk("glitch_mem_e16", {12'd0, rst_mem}, 13'd0);

        // 5. Lock loss and soft request seen on the same edge in RELEASE.
        locked = 1'b0;
        ticks(2);
        soft_rst_req = 1'b1;
        ticks(1);
        soft_rst_req = 1'b0;
        chk("both_assert", dutv(), 13'b1111_0_00000011);
        ticks(3);
        chk("both_counted_once", {5'd0, lock_loss_cnt}, 13'd3);

        // 6. Saturation of the loss counter.
        for (int k = 0; k < 300; k++) begin
            locked = 1'b1;
            ticks(11);
            locked = 1'b0;
            ticks(4);
        end
        chk("loss_saturated", dutv(), 13'b1111_0_11111111);

        // Async reset mid-RELEASE.
        locked = 1'b1;
        ticks(13);
        chk("pre_async_release", {11'd0, rst_mem, rst_core}, 13'b01);
        #2 rst = 1'b1;
        #1 chk("async_reset", dutv(), 13'b1111_0_00000000);
        @(posedge clk);
        #1 rst = 1'b0;
        ticks(12);
        chk("post_async_mem", {12'd0, rst_mem}, 13'd0);

        run_cmp = 1'b0;
        ticks(1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
